// File: rtl/multi_clk_gen.sv
// Multi-channel programmable clock/tick generator. Config is shadowed per channel
// and only promoted to the active registers at a period boundary or while parked.
module multi_clk_gen_ch #(
  parameter int CNT_W   = 24,
  parameter int DEF_DIV = 20000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wdiv_i,
  input  logic [CNT_W-1:0] whigh_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pend_o
);
  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_DIV / 2);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] div_a_q, div_a_d, high_a_q, high_a_d;
  logic [CNT_W-1:0] div_s_q, div_s_d, high_s_q, high_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
  logic             term, load;

  always_comb begin
    term     = (cnt_q == div_a_q - ONE);
    cnt_inc  = cnt_q + ONE;
    // Load uses the pre-edge shadow; a same-cycle write re-arms pend below.
    load     = pend_q & (~en_i | term);
    div_a_d  = load ? div_s_q  : div_a_q;
    high_a_d = load ? high_s_q : high_a_q;
    div_s_d  = div_s_q;
    high_s_d = high_s_q;
    pend_d   = pend_q & ~load;
    if (wr_i) begin
      div_s_d  = wdiv_i;
      high_s_d = whigh_i;
      pend_d   = 1'b1;
    end
    cnt_d  = cnt_inc;
    tick_d = 1'b0;
    clk_d  = 1'b0;
    if (!en_i) begin
      cnt_d = div_a_d - ONE;
    end else if (term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      clk_d  = (high_a_d != '0);
    end else begin
      clk_d = (cnt_inc < high_a_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_a_q  <= DEF_D;
      high_a_q <= DEF_H;
      div_s_q  <= DEF_D;
      high_s_q <= DEF_H;
      cnt_q    <= DEF_D - ONE;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_a_q  <= div_a_d;
      high_a_q <= high_a_d;
      div_s_q  <= div_s_d;
      high_s_q <= high_s_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign pend_o    = pend_q;
endmodule

module multi_clk_gen #(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = 24,
  parameter  int DEF_DIV = 20000,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);
  logic [CNT_W-1:0] div_c, high_c;

  // Clamp once, shared by all channels: period >= 2, high time <= period.
  assign div_c  = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
  assign high_c = (cfg_high > div_c) ? div_c : cfg_high;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);
    multi_clk_gen_ch #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en[i]),
      .wr_i      (cfg_we && (cfg_ch == IDX)),
      .wdiv_i    (div_c),
      .whigh_i   (high_c),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i]),
      .pend_o    (pend[i])
    );
  end
endmodule

// File: tb/tb_multi_clk_gen.sv
// Bench for multi_clk_gen: directed vector table, corner sequences and random
// traffic checked against a period-position model of each channel.
module tb_multi_clk_gen;
  localparam int NUM_CH = 5, CNT_W = 8, DEF_DIV = 10, CH_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div, cfg_high;
  logic [NUM_CH-1:0] clk_out, tick, pend;

  multi_clk_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  // Model: ph = position of the visible cycle inside the period, -1 = parked/off.
  int m_div_a[NUM_CH], m_high_a[NUM_CH], m_div_s[NUM_CH], m_high_s[NUM_CH], m_ph[NUM_CH];
  bit m_pend[NUM_CH];

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div_a[i] = DEF_DIV;     m_div_s[i] = DEF_DIV;
      m_high_a[i] = DEF_DIV / 2; m_high_s[i] = DEF_DIV / 2;
      m_ph[i] = -1;             m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_apply(input int i);
    m_div_a[i] = m_div_s[i];
    m_high_a[i] = m_high_s[i];
    m_pend[i] = 1'b0;
  endtask

  task automatic model_edge();
    int d;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!en[i]) begin
        if (m_pend[i]) model_apply(i);
        m_ph[i] = -1;
      end else begin
        m_ph[i] = (m_ph[i] < 0 || m_ph[i] >= m_div_a[i] - 1) ? 0 : m_ph[i] + 1;
        if (m_ph[i] == 0 && m_pend[i]) model_apply(i);
      end
      if (cfg_we && int'(cfg_ch) == i) begin
        d = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        m_div_s[i] = d;
        m_high_s[i] = (int'(cfg_high) > d) ? d : int'(cfg_high);
        m_pend[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] m_clk();
    for (int i = 0; i < NUM_CH; i++) m_clk[i] = (m_ph[i] >= 0) && (m_ph[i] < m_high_a[i]);
  endfunction
  function automatic logic [NUM_CH-1:0] m_tick();
    for (int i = 0; i < NUM_CH; i++) m_tick[i] = (m_ph[i] == 0);
  endfunction
  function automatic logic [NUM_CH-1:0] m_pnd();
    for (int i = 0; i < NUM_CH; i++) m_pnd[i] = m_pend[i];
  endfunction

  task automatic chk(input string nm, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "/clk_out"}, clk_out, m_clk());
    chk({nm, "/tick"}, tick, m_tick());
    chk({nm, "/pend"}, pend, m_pnd());
  endtask

  // Inputs are stable from the negedge; model advances in step with the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      step();
      chk_model(nm);
    end
  endtask

  task automatic wr(input int ch, input int dv, input int hi, input string nm);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(dv); cfg_high = CNT_W'(hi);
    step();
    chk_model(nm);
    cfg_we = 1'b0;
  endtask

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic              we;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  dv, hi;
    logic [NUM_CH-1:0] e_clk, e_tick, e_pend;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int hi, tk, found;
    // Startup after reset (DEF_DIV=10) with a mid-period write of ch1 div=4 high=1.
    tbl[0]  = '{5'h1f, 1'b0, 3'd0, 8'd0, 8'd0, 5'b11111, 5'b11111, 5'b00000};
    tbl[1]  = '{5'h1f, 1'b0, 3'd0, 8'd0, 8'd0, 5'b11111, 5'b00000, 5'b00000};
    tbl[2]  = '{5'h1f, 1'b1, 3'd1, 8'd4, 8'd1, 5'b11111, 5'b00000, 5'b00010};
    tbl[3]  = '{5'h1f, 1'b0, 3'd0, 8'd0, 8'd0, 5'b11111, 5'b00000, 5'b00010};
    tbl[4]  = '{5'h1f, 1'b0, 3'd0, 8'd0, 8'd0, 5'b11111, 5'b00000, 5'b00010};
    for (int k = 5; k < 10; k++)
      tbl[k] = '{5'h1f, 1'b0, 3'd0, 8'd0, 8'd0, 5'b00000, 5'b00000, 5'b00010};
    tbl[10] = '{5'h1f, 1'b0, 3'd0, 8'd0, 8'd0, 5'b11111, 5'b11111, 5'b00000};
    for (int k = 11; k < 14; k++)
      tbl[k] = '{5'h1f, 1'b0, 3'd0, 8'd0, 8'd0, 5'b11101, 5'b00000, 5'b00000};
    tbl[14] = '{5'h1f, 1'b0, 3'd0, 8'd0, 8'd0, 5'b11111, 5'b00010, 5'b00000};
    tbl[15] = '{5'h1f, 1'b0, 3'd0, 8'd0, 8'd0, 5'b00000, 5'b00000, 5'b00000};

    rst_n = 1'b0; en = '1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset/clk_out", clk_out, '0);
    chk("reset/tick", tick, '0);
    chk("reset/pend", pend, '0);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      en = tbl[k].en; cfg_we = tbl[k].we; cfg_ch = tbl[k].ch;
      cfg_div = tbl[k].dv; cfg_high = tbl[k].hi;
      step();
      chk($sformatf("tbl%0d/clk_out", k), clk_out, tbl[k].e_clk);
      chk($sformatf("tbl%0d/tick", k), tick, tbl[k].e_tick);
      chk($sformatf("tbl%0d/pend", k), pend, tbl[k].e_pend);
    end
    cfg_we = 1'b0;

    // Clamp: div 0 -> 2 with high clamped to 2, then high 0.
    wr(0, 0, 7, "clamp_wr");
    run(12, "clamp_run");
    hi = 0; tk = 0;
    for (int k = 0; k < 6; k++) begin step(); chk_model("clamp2"); hi += clk_out[0]; tk += tick[0]; end
    chk_int("clamp2_high_cycles", hi, 6);
    chk_int("clamp2_ticks", tk, 3);
    wr(0, 6, 0, "clamp_wr6");
    run(10, "clamp6_run");
    hi = 0; tk = 0;
    for (int k = 0; k < 12; k++) begin step(); chk_model("clamp6"); hi += clk_out[0]; tk += tick[0]; end
    chk_int("clamp6_high_cycles", hi, 0);
    chk_int("clamp6_ticks", tk, 2);

    // Disabled channel takes its config while parked, restarts cleanly.
    en[2] = 1'b0;
    wr(2, 8, 3, "dis_wr");
    run(6, "dis_run");
    chk_int("dis_clk", clk_out[2], 0);
    chk_int("dis_tick", tick[2], 0);
    chk_int("dis_pend", pend[2], 0);
    en[2] = 1'b1;
    step(); chk_model("reen");
    chk_int("reen_tick", tick[2], 1);
    chk_int("reen_clk", clk_out[2], 1);
    hi = 1; tk = 0;
    for (int k = 1; k < 8; k++) begin step(); chk_model("reen_per"); hi += clk_out[2]; tk += tick[2]; end
    chk_int("reen_high_cycles", hi, 3);
    chk_int("reen_mid_ticks", tk, 0);
    step(); chk_model("reen_wrap");
    chk_int("reen_period8_tick", tick[2], 1);

    // Write landing exactly on the terminal edge while a shadow is pending.
    wr(3, 12, 5, "term_wr12");
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (m_ph[3] == m_div_a[3] - 1 && m_pend[3]) begin found = 1; break; end
      step(); chk_model("term_wait");
    end
    chk_int("term_found", found, 1);
    wr(3, 3, 1, "term_wr3");
    chk_int("term_pend_kept", pend[3], 1);
    chk_int("term_tick", tick[3], 1);
    tk = 0;
    for (int k = 1; k < 12; k++) begin step(); chk_model("term_p12"); tk += tick[3]; end
    chk_int("term_p12_mid_ticks", tk, 0);
    step(); chk_model("term_p12_end");
    chk_int("term_p12_tick", tick[3], 1);
    chk_int("term_p3_loaded", pend[3], 0);
    run(2, "term_p3");
    step(); chk_model("term_p3_end");
    chk_int("term_p3_tick", tick[3], 1);
    wr(5, 2, 1, "bad_ch_wr");
    chk("bad_ch_pend", pend, '0);
    run(12, "bad_ch_run");

    // Reset mid-period drops the pending write.
    wr(1, 7, 2, "rst_wr");
    chk_int("rst_pend_pre", pend[1], 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async/clk_out", clk_out, '0);
    chk("rst_async/tick", tick, '0);
    chk("rst_async/pend", pend, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tk = 0;
    for (int k = 0; k < 20; k++) begin step(); chk_model("post_rst"); tk += tick[1]; end
    chk_int("post_rst_ticks", tk, 2);
    chk_int("post_rst_pend", pend[1], 0);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_ch   = CH_W'($urandom_range(0, 7));
      cfg_div  = CNT_W'($urandom_range(0, 20));
      cfg_high = CNT_W'($urandom_range(0, 22));
      step();
      chk_model("rand");
    end
    cfg_we = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/multi_clk_gen.md
# multi_clk_gen

Multi-channel programmable clock/tick generator. It is the parametrised successor of the fixed four-rate LED clock divider. Each of NUM_CH channels has its own runtime-written period and high time. Updates are double-buffered and applied only at the channel's period boundary, so outputs never glitch. It sits between the system clock and the heartbeat/PWM LED logic, which consume `clk_out` as a level and `tick` as a one-cycle enable.

## Interface
- `NUM_CH`, 4: number of independent channels (1..16).
- `CNT_W`, 24: counter/divisor width in bits.
- `DEF_DIV`, 20000: reset period in clk cycles for every channel; 2 ≤ DEF_DIV < 2^CNT_W.
- `CH_W`, derived: max(1, clog2(NUM_CH)).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  NUM_CH  per-channel run enable.
- `cfg_we`  in  1  config write strobe, one write per cycle, always accepted.
- `cfg_ch`  in  CH_W  target channel. Writes with cfg_ch ≥ NUM_CH are ignored.
- `cfg_div`  in  CNT_W  period in clk cycles.
- `cfg_high`  in  CNT_W  high time in clk cycles.
- `clk_out`  out  NUM_CH  per-channel divided clock, registered.
- `tick`  out  NUM_CH  one-cycle pulse marking the first cycle of each period, registered.
- `pend`  out  NUM_CH  shadow config written but not yet active.

## Operation
- Per channel i, the block holds:
  - Active registers: `div_a`, `high_a`.
  - Shadow registers: `div_s`, `high_s`.
  - Flag `pend`.
  - Counter `cnt` (CNT_W bits).
- Write (cfg_we=1, cfg_ch=i): `div_s` ← max(cfg_div, 2); `high_s` ← min(cfg_high, clamped div); `pend` ← 1.
  - Back-to-back writes to the same channel: the last write wins.
- Enabled channel, each edge:
  - Terminal (cnt == div_a−1):
    - If pend: div_a/high_a ← shadow and pend ← 0 (unless written this same cycle).
    - cnt ← 0; tick ← 1; clk_out ← (new high_a ≠ 0).
  - Otherwise: cnt ← cnt+1; tick ← 0; clk_out ← (cnt+1 < high_a).
- Result: clk_out is high for exactly high_a cycles starting at the tick cycle, then low for div_a−high_a cycles.
  - high_a = 0: always low.
  - high_a = div_a: always high; tick still pulses.
- Disabled channel (en[i]=0), each edge:
  - clk_out ← 0; tick ← 0.
  - If pend: active ← shadow and pend ← 0.
  - cnt ← (active div after any load) − 1, so the channel is parked at terminal.
- Write coinciding with a load for the same channel: the load uses the shadow value held before the edge. The new write lands in the shadow, pend stays 1, and it is applied at the next boundary.
- Channels are fully independent; there is no cross-channel phase relationship.

## Timing
- Reset (async assert, sync use after release), all channels:
  - div_a = div_s = DEF_DIV; high_a = high_s = DEF_DIV/2 (floor).
  - cnt = DEF_DIV−1; clk_out = 0; tick = 0; pend = 0.
- en rise: the first edge with en=1 wraps the counter. tick=1 and clk_out=(high_a≠0) are visible in the following cycle, i.e. 1 cycle of latency.
- en fall: clk_out and tick are 0 from the next cycle. Re-enable restarts a full period; no partial period is emitted.
- Config latency:
  - pend rises the cycle after the write.
  - On a running channel, the new config takes effect on the first period starting after the current period ends. It is never applied mid-period.
- Period: exactly div_a cycles between consecutive ticks. This holds for div_a = 2 (tick every other cycle).
- Arithmetic is unsigned CNT_W-bit with no overflow, since cnt ≤ div_a−1 < 2^CNT_W.
- Reset mid-operation returns to the reset values immediately. Pending writes are discarded.

## Test plan
- Reset with DEF_DIV=10, en=all 1 -> first tick 1 cycle after rst_n release. Ticks every 10 cycles; clk_out 5 high / 5 low; pend=0.
- Write ch1 div=4 high=1 mid-period -> pend[1]=1 until ch1's boundary. The current 10-cycle period completes, then period 4 with 1 high. Ch0/2/3 are unchanged.
- Clamp: write div=0 high=7 -> div 2, high 2: tick every 2 cycles, clk_out constant 1. Then write div=6 high=0 -> clk_out constant 0, tick every 6 cycles.
- en[2] low for 7 cycles with a write div=8 high=3 -> clk_out/tick 0 and pend cleared while disabled. On re-enable, tick 1 cycle later, then an 8-cycle period with 3 high.
- Write to the channel in its terminal cycle (shadow div=12 already pending, new write div=3) -> div 12 is applied for the next period, pend stays 1, and div 3 is applied after that. A write with cfg_ch ≥ NUM_CH has no effect.
- Assert rst_n mid-period with pend=1 -> all outputs 0 immediately. After release the channel runs at DEF_DIV and the pending write is lost.
